// File: rtl/aud_play_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : aud_play_engine_if
//  Description : Control, SRAM read, DAC and status bundle of the playback engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aud_play_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 4
);
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [1:0]        i_mode;
  logic [SPD_W-1:0]  i_speed;
  logic              i_reverse;
  logic              i_loop;
  logic [ADDR_W-1:0] i_len;
  logic              i_daclrck;
  logic [DATA_W-1:0] i_sram_data;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_dac_data;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_pause, i_stop, i_mode, i_speed, i_reverse, i_loop, i_len,
    output i_daclrck, i_sram_data,
    input  o_sram_addr, o_dac_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_mode, i_speed, i_reverse, i_loop, i_len,
    input  i_daclrck, i_sram_data,
    output o_sram_addr, o_dac_data, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/aud_play_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aud_play_engine
//  Description : SRAM-to-DAC playback engine, one sample per LR clock rising edge,
//                normal/fast/slow-hold/slow-linear, forward/reverse, one-shot/loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_play_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  aud_play_engine_if.slave bus
);

  localparam logic [1:0] c_mode_normal = 2'b00;
  localparam logic [1:0] c_mode_fast   = 2'b01;
  localparam logic [1:0] c_mode_hold   = 2'b10;
  localparam logic [1:0] c_mode_lin    = 2'b11;

  localparam logic [SPD_W-1:0]  c_k_one   = {{(SPD_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_FETCH = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic                   r_prev_lrck;
  logic [ADDR_W-1:0]      r_addr,   w_addr_nxt;
  logic [DATA_W-1:0]      r_dac,    w_dac_nxt;
  logic [DATA_W-1:0]      r_s0,     w_s0_nxt;
  logic [SPD_W-1:0]       r_k,      w_k_nxt;
  logic signed [DATA_W:0] r_step,   w_step_nxt;
  logic [1:0]             r_mode,   w_mode_nxt;
  logic                   w_done;

  logic                   w_lrck_rise;
  logic [SPD_W-1:0]       w_n;
  logic [ADDR_W-1:0]      w_inc;
  logic [ADDR_W:0]        w_fwd_sum;
  logic                   w_end;
  logic [ADDR_W-1:0]      w_adv_addr;
  logic [SPD_W-1:0]       w_k_eff;
  logic [SPD_W-1:0]       w_k_wrap;
  logic                   w_advance;
  logic signed [DATA_W:0] w_diff;
  logic signed [DATA_W:0] w_n_s;
  logic signed [DATA_W:0] w_div;
  logic signed [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0]      w_sat;

  assign w_lrck_rise = bus.i_daclrck & ~r_prev_lrck;
  assign w_n         = (bus.i_speed == '0) ? c_k_one : bus.i_speed;
  assign w_inc       = (bus.i_mode == c_mode_fast) ? {{(ADDR_W-SPD_W){1'b0}}, w_n} : c_addr_one;

  // One extra bit on the forward sum so a step past the top of the address space still reads as "end".
  assign w_fwd_sum  = {1'b0, r_addr} + {1'b0, w_inc};
  assign w_end      = bus.i_reverse ? (r_addr < w_inc) : (w_fwd_sum > {1'b0, bus.i_len});
  assign w_adv_addr = w_end ? ((bus.i_loop && bus.i_reverse) ? bus.i_len : '0)
                            : (bus.i_reverse ? (r_addr - w_inc) : w_fwd_sum[ADDR_W-1:0]);

  assign w_k_eff   = (bus.i_mode != r_mode) ? '0 : r_k;
  assign w_k_wrap  = (w_k_eff == (w_n - c_k_one)) ? '0 : (w_k_eff + c_k_one);
  assign w_advance = ~bus.i_mode[1] | (w_k_eff == '0);

  assign w_diff = $signed({bus.i_sram_data[DATA_W-1], bus.i_sram_data})
                - $signed({r_s0[DATA_W-1], r_s0});
  assign w_n_s  = $signed({{(DATA_W+1-SPD_W){1'b0}}, w_n});
  assign w_div  = w_diff / w_n_s;

  // Saturate when the top three sum bits disagree, i.e. the result left the DATA_W range.
  assign w_sum = $signed({{2{r_dac[DATA_W-1]}}, r_dac}) + $signed({r_step[DATA_W], r_step});
  assign w_sat = ((w_sum[DATA_W+1:DATA_W-1] == 3'b000) || (w_sum[DATA_W+1:DATA_W-1] == 3'b111))
               ? w_sum[DATA_W-1:0]
               : (w_sum[DATA_W+1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_dac_nxt   = r_dac;
    w_s0_nxt    = r_s0;
    w_k_nxt     = r_k;
    w_step_nxt  = r_step;
    w_mode_nxt  = r_mode;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_RUN;
          w_addr_nxt  = bus.i_reverse ? bus.i_len : '0;
          w_k_nxt     = '0;
          w_mode_nxt  = bus.i_mode;
        end
      end
      S_RUN: begin
        if (bus.i_pause)      w_state_nxt = S_PAUSE;
        else if (w_lrck_rise) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        w_mode_nxt = bus.i_mode;
        w_k_nxt    = bus.i_mode[1] ? w_k_wrap : '0;
        if (w_advance) begin
          w_dac_nxt  = bus.i_sram_data;
          w_addr_nxt = w_adv_addr;
          if (bus.i_mode == c_mode_lin) w_s0_nxt = bus.i_sram_data;
        end else if (bus.i_mode == c_mode_lin) begin
          w_dac_nxt = w_sat;
        end

        if (w_advance && w_end && !bus.i_loop) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
          w_k_nxt     = '0;
          w_done      = 1'b1;
        end else if (w_advance && (bus.i_mode == c_mode_lin)) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = bus.i_pause ? S_PAUSE : S_RUN;
        end
      end
      S_FETCH: begin
        w_step_nxt  = w_div;
        w_state_nxt = bus.i_pause ? S_PAUSE : S_RUN;
      end
      S_PAUSE: begin
        if (!bus.i_pause && w_lrck_rise) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (bus.i_stop) begin
      w_state_nxt = S_IDLE;
      w_dac_nxt   = '0;
      w_addr_nxt  = '0;
      w_k_nxt     = '0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_prev_lrck <= 1'b0;
      r_addr      <= '0;
      r_dac       <= '0;
      r_s0        <= '0;
      r_k         <= '0;
      r_step      <= '0;
      r_mode      <= c_mode_normal;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_lrck <= bus.i_daclrck;
      r_addr      <= w_addr_nxt;
      r_dac       <= w_dac_nxt;
      r_s0        <= w_s0_nxt;
      r_k         <= w_k_nxt;
      r_step      <= w_step_nxt;
      r_mode      <= w_mode_nxt;
    end
  end

  assign bus.o_sram_addr = r_addr;
  assign bus.o_dac_data  = r_dac;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = w_done;

  // Kept for readability of the mode table; hold mode needs no dedicated action.
  logic w_unused;
  assign w_unused = (c_mode_hold == 2'b10);

endmodule
`default_nettype wire

// File: tb/tb_aud_play_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aud_play_engine
//  Description : Directed bench for aud_play_engine with a combinational SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_play_engine;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] lr_cnt = 4'd0;
  logic [15:0] mem [0:15];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp4 [9] = '{0, 25, 50, 75, 100, 50, 0, -50, -100};

  always #5 clk = ~clk;

  aud_play_engine_if bus ();

  aud_play_engine dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always @(negedge clk) lr_cnt = lr_cnt + 4'd1;
  assign bus.i_daclrck   = lr_cnt[3];
  assign bus.i_sram_data = mem[bus.o_sram_addr[3:0]];

  always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge bus.i_daclrck);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string tag, input int d, input int a);
    nxt();
    chk({tag, " dac"}, $signed(bus.o_dac_data), d);
    chk({tag, " addr"}, bus.o_sram_addr, a);
  endtask

  task automatic start_play(input logic [1:0] m, input int n, input logic rev, input logic lp, input int len);
    @(posedge bus.i_daclrck);
    repeat (2) @(negedge clk);
    bus.i_mode    = m;
    bus.i_speed   = n[3:0];
    bus.i_reverse = rev;
    bus.i_loop    = lp;
    bus.i_len     = len[19:0];
    bus.i_start   = 1'b1;
    @(negedge clk);
    bus.i_start   = 1'b0;
  endtask

  task automatic stop_play();
    @(negedge clk);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 2'b00;
    bus.i_speed = 4'd1; bus.i_reverse = 1'b0; bus.i_loop = 1'b0; bus.i_len = 20'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'(10 * i);

    repeat (3) @(negedge clk);
    chk("reset dac", $signed(bus.o_dac_data), 0);
    chk("reset addr", bus.o_sram_addr, 0);
    chk("reset busy", bus.o_busy, 0);
    chk("reset done", bus.o_done, 0);
    rst_n = 1'b1;

    // normal forward one-shot
    start_play(2'b00, 1, 1'b0, 1'b0, 3);
    chk_s("t1 s0", 0, 1);
    chk_s("t1 s1", 10, 2);
    chk_s("t1 s2", 20, 3);
    chk_s("t1 s3", 30, 0);
    chk("t1 busy", bus.o_busy, 0);
    chk("t1 done", done_cnt, 1);

    // start together with stop
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    @(negedge clk);
    chk("start+stop busy", bus.o_busy, 0);

    // fast N=3 with wrap, plus an ignored start
    start_play(2'b01, 3, 1'b0, 1'b1, 8);
    chk_s("t2 s0", 0, 3);
    chk_s("t2 s1", 30, 6);
    chk_s("t2 s2", 60, 0);
    chk_s("t2 s3", 0, 3);
    chk_s("t2 s4", 30, 6);
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    chk_s("t2 ignored start", 60, 0);
    stop_play();
    chk("t2 stop busy", bus.o_busy, 0);
    chk("t2 stop dac", $signed(bus.o_dac_data), 0);
    chk("t2 stop addr", bus.o_sram_addr, 0);

    // slow-hold N=4
    start_play(2'b10, 4, 1'b0, 1'b0, 8);
    for (int i = 0; i < 8; i++) chk_s("t3 hold", (i < 4) ? 0 : 10, (i < 4) ? 1 : 2);
    stop_play();

    // slow-linear N=4
    mem[0] = 16'd0; mem[1] = 16'd100; mem[2] = -16'sd100;
    start_play(2'b11, 4, 1'b0, 1'b0, 2);
    for (int i = 0; i < 9; i++) begin
      nxt();
      chk("t4 lin", $signed(bus.o_dac_data), exp4[i]);
    end
    chk("t4 done", done_cnt, 2);
    chk("t4 busy", bus.o_busy, 0);
    nxt();
    chk("t4 hold last", $signed(bus.o_dac_data), -100);

    // slow-linear step truncates toward zero
    mem[1] = -16'sd7;
    start_play(2'b11, 2, 1'b0, 1'b0, 1);
    nxt(); chk("t4b s0", $signed(bus.o_dac_data), 0);
    nxt(); chk("t4b s1", $signed(bus.o_dac_data), -3);
    nxt(); chk("t4b s2", $signed(bus.o_dac_data), -7);
    chk("t4b done", done_cnt, 3);

    // reverse loop with pause
    mem[0] = 16'd0; mem[1] = 16'd10; mem[2] = 16'd20;
    start_play(2'b00, 1, 1'b1, 1'b1, 2);
    chk_s("t5 s0", 20, 1);
    chk_s("t5 s1", 10, 0);
    chk_s("t5 s2", 0, 2);
    chk_s("t5 s3", 20, 1);
    bus.i_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_s("t5 paused", 20, 1);
      chk("t5 paused busy", bus.o_busy, 1);
    end
    bus.i_pause = 1'b0;
    chk_s("t5 resume edge", 20, 1);
    chk_s("t5 resumed", 10, 0);
    stop_play();

    // stop and reset mid slow-linear
    mem[0] = 16'd40; mem[1] = 16'd100; mem[2] = -16'sd100;
    start_play(2'b11, 4, 1'b0, 1'b0, 2);
    nxt(); chk("t6 a s0", $signed(bus.o_dac_data), 40);
    nxt(); chk("t6 a s1", $signed(bus.o_dac_data), 55);
    stop_play();
    chk("t6 stop busy", bus.o_busy, 0);
    chk("t6 stop dac", $signed(bus.o_dac_data), 0);
    chk("t6 stop addr", bus.o_sram_addr, 0);
    start_play(2'b11, 4, 1'b0, 1'b0, 2);
    chk_s("t6 b s0", 40, 1);
    nxt(); chk("t6 b s1", $signed(bus.o_dac_data), 55);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("t6 rst dac", $signed(bus.o_dac_data), 0);
    chk("t6 rst addr", bus.o_sram_addr, 0);
    chk("t6 rst busy", bus.o_busy, 0);
    rst_n = 1'b1;
    start_play(2'b11, 4, 1'b0, 1'b0, 2);
    chk_s("t6 c s0", 40, 1);
    nxt(); chk("t6 c s1", $signed(bus.o_dac_data), 55);
    stop_play();
    chk("t6 no done", done_cnt, 3);

    // single-word buffer
    start_play(2'b00, 1, 1'b0, 1'b0, 0);
    chk_s("len0 s0", 40, 0);
    chk("len0 busy", bus.o_busy, 0);
    chk("len0 done", done_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
